gate_round_ctrl: RTL

Parametrised round controller for the logic-gate guessing game. It hides a target gate and evaluates the player's two operand keys through that gate onto `outwire`. The player steps a selection pointer and confirms a guess; a miss triggers a timed VGA blankout. It replaces the fixed 8-gate one-hot controller: the gate count is parametrised, indices are binary, target order is pseudo-random, and it adds a miss counter and a done flag. It sits between the board keys and the VGA/timer/HEX logic.

---
 rtl/gate_round_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/gate_round_ctrl.sv
// Round controller for the logic-gate guessing game: hides a target gate, evaluates the
// operand keys through it, and runs the select/confirm/miss-penalty round flow.
`timescale 1ns/1ps

module gate_round_ctrl #(
    parameter int N_GATES      = 8,
    parameter int BLANK_CYCLES = 25_000_000,
    parameter int IDX_W        = $clog2(N_GATES)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               in1,
    input  logic               in2,
    input  logic               switch_select,
    input  logic               confirm_select,
    output logic               outwire,
    output logic [IDX_W-1:0]   selected_idx,
    output logic [IDX_W-1:0]   current_idx,
    output logic [N_GATES-1:0] completed,
    output logic               timer_en,
    output logic               vga_blankout,
    output logic               done,
    output logic [7:0]         miss_count
);

    localparam int               CNT_W      = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W:0]   N_EXT      = N_GATES[IDX_W:0];
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_GATES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PICK,
        S_PLAY,
        S_BLANK,
        S_DONE
    } state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   ptr, ptr_n;
    logic [IDX_W-1:0]   cur_n, sel_n;
    logic [N_GATES-1:0] comp_n;
    logic [7:0]         miss_n;
    logic [CNT_W-1:0]   blank_cnt, cnt_n;
    logic               timer_n, blank_n, done_n;

    logic [1:0] in1_sync, in2_sync;
    logic [2:0] sw_sync, cf_sync;
    logic       sw_press, cf_press;
    logic       op_a, op_b;

    logic [7:0]       lfsr;
    logic             lfsr_fb;
    logic [IDX_W-1:0] lfsr_idx, ptr_seed;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] x);
        return (x == LAST_IDX) ? '0 : x + 1'b1;
    endfunction

    function automatic logic gate_fn(input logic [2:0] g, input logic a, input logic b);
        case (g)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~(a & b);
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    // Keys idle high, so synchronisers reset to "released" and no press appears out of reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            in1_sync <= '1;
            in2_sync <= '1;
            sw_sync  <= '1;
            cf_sync  <= '1;
        end else begin
            in1_sync <= {in1_sync[0], in1};
            in2_sync <= {in2_sync[0], in2};
            sw_sync  <= {sw_sync[1:0], switch_select};
            cf_sync  <= {cf_sync[1:0], confirm_select};
        end
    end

    assign sw_press = ~sw_sync[1] & sw_sync[2];
    assign cf_press = ~cf_sync[1] & cf_sync[2];
    assign op_a     = ~in1_sync[1];
    assign op_b     = ~in2_sync[1];

    // x^8+x^6+x^5+x^4+1, free-running so the target order depends on when the player acts.
    assign lfsr_fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign lfsr_idx = lfsr[IDX_W-1:0];
    assign ptr_seed = ({1'b0, lfsr_idx} >= N_EXT) ? lfsr_idx - N_EXT[IDX_W-1:0] : lfsr_idx;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lfsr <= 8'h01;
        else         lfsr <= {lfsr[6:0], lfsr_fb};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            ptr          <= '0;
            current_idx  <= '0;
            selected_idx <= '0;
            completed    <= '0;
            miss_count   <= '0;
            blank_cnt    <= '0;
            timer_en     <= 1'b0;
            vga_blankout <= 1'b0;
            done         <= 1'b0;
            outwire      <= 1'b0;
        end else begin
            state        <= state_n;
            ptr          <= ptr_n;
            current_idx  <= cur_n;
            selected_idx <= sel_n;
            completed    <= comp_n;
            miss_count   <= miss_n;
            blank_cnt    <= cnt_n;
            timer_en     <= timer_n;
            vga_blankout <= blank_n;
            done         <= done_n;
            outwire      <= gate_fn(3'(current_idx), op_a, op_b);
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cur_n   = current_idx;
        sel_n   = selected_idx;
        comp_n  = completed;
        miss_n  = miss_count;
        cnt_n   = blank_cnt;
        timer_n = timer_en;
        blank_n = vga_blankout;
        done_n  = done;
        case (state)
            S_IDLE: begin
                if (sw_press || cf_press) begin
                    state_n = S_PICK;
                    ptr_n   = ptr_seed;
                    timer_n = 1'b1;
                end
            end
            // Linear probe from the random start to the next uncompleted gate.
            S_PICK: begin
                if (!completed[ptr]) begin
                    cur_n   = ptr;
                    state_n = S_PLAY;
                end else begin
                    ptr_n = wrap_inc(ptr);
                end
            end
            S_PLAY: begin
                if (cf_press) begin
                    if (selected_idx == current_idx) begin
                        comp_n[current_idx] = 1'b1;
                        if (&comp_n) begin
                            state_n = S_DONE;
                            timer_n = 1'b0;
                            done_n  = 1'b1;
                        end else begin
                            state_n = S_PICK;
                            ptr_n   = ptr_seed;
                        end
                    end else begin
                        if (miss_count != 8'hFF) miss_n = miss_count + 8'd1;
                        cnt_n   = BLANK_LOAD;
                        blank_n = 1'b1;
                        state_n = S_BLANK;
                    end
                end else if (sw_press) begin
                    sel_n = wrap_inc(selected_idx);
                end
            end
            S_BLANK: begin
                if (blank_cnt == '0) begin
                    state_n = S_PLAY;
                    blank_n = 1'b0;
                end else begin
                    cnt_n = blank_cnt - 1'b1;
                end
            end
            S_DONE: ;
            default: state_n = S_IDLE;
        endcase
    end

endmodule
